// File: rtl/hilo_unit_pkg.sv
// Shared CPU defines: data width default, HI/LO write-record field widths, ALU control codes.
package hilo_unit_pkg;

    localparam int CPU_DW    = 32;
    localparam int HILO_WE_W = 1;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLTU  = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_LUI   = 4'd11,
        ALU_MULT  = 4'd12,
        ALU_MULTU = 4'd13,
        ALU_MTHI  = 4'd14,
        ALU_MTLO  = 4'd15
    } alu_op_e;

    // A write record carries a real write iff at least one enable is set.
    function automatic logic wr_valid(input logic [HILO_WE_W-1:0] hi_we,
                                      input logic [HILO_WE_W-1:0] lo_we);
        return (|hi_we) | (|lo_we);
    endfunction

endpackage

// File: rtl/hilo_stage.sv
// One HI/LO write-record pipeline register with bubble > load > hold priority.
module hilo_stage
    import hilo_unit_pkg::*;
#(
    parameter int DW = CPU_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 bubble_i,
    input  logic [HILO_WE_W-1:0] hi_we_i,
    input  logic [HILO_WE_W-1:0] lo_we_i,
    input  logic [DW-1:0]        hi_i,
    input  logic [DW-1:0]        lo_i,
    output logic [HILO_WE_W-1:0] hi_we_o,
    output logic [HILO_WE_W-1:0] lo_we_o,
    output logic [DW-1:0]        hi_o,
    output logic [DW-1:0]        lo_o
);

    logic [HILO_WE_W-1:0] hi_we_q, hi_we_d;
    logic [HILO_WE_W-1:0] lo_we_q, lo_we_d;
    logic [DW-1:0]        hi_q, hi_d;
    logic [DW-1:0]        lo_q, lo_d;

    always_comb begin
        hi_we_d = hi_we_q;
        lo_we_d = lo_we_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (bubble_i) begin
            hi_we_d = '0;
            lo_we_d = '0;
            hi_d    = '0;
            lo_d    = '0;
        end else if (load_i) begin
            hi_we_d = hi_we_i;
            lo_we_d = lo_we_i;
            hi_d    = hi_i;
            lo_d    = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_we_q <= '0;
            lo_we_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            hi_we_q <= hi_we_d;
            lo_we_q <= lo_we_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_we_o = hi_we_q;
    assign lo_we_o = lo_we_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register file with M/W write pipeline; define HILO_FWD_EN for M/W forwarding,
// otherwise in-flight writes raise stall_req against MFHI/MFLO.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DW = CPU_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          e_hi_we,
    input  logic          e_lo_we,
    input  logic [DW-1:0] e_hi,
    input  logic [DW-1:0] e_lo,
    input  logic          e_rd_hi,
    input  logic          e_rd_lo,
    output logic [DW-1:0] hi_out,
    output logic [DW-1:0] lo_out,
    output logic          stall_req
);

    logic [HILO_WE_W-1:0] m_hi_we, m_lo_we, w_hi_we, w_lo_we;
    logic [DW-1:0]        m_hi, m_lo, w_hi, w_lo;
    logic [DW-1:0]        hi_q, lo_q;

    hilo_stage #(.DW(DW)) u_m (
        .clk      (clk),
        .rst      (rst),
        .load_i   (~stall),
        .bubble_i (flush),
        .hi_we_i  (HILO_WE_W'(e_hi_we)),
        .lo_we_i  (HILO_WE_W'(e_lo_we)),
        .hi_i     (e_hi),
        .lo_i     (e_lo),
        .hi_we_o  (m_hi_we),
        .lo_we_o  (m_lo_we),
        .hi_o     (m_hi),
        .lo_o     (m_lo)
    );

    // W always drains into commit; a stalled M must not be duplicated, so W takes a bubble.
    hilo_stage #(.DW(DW)) u_w (
        .clk      (clk),
        .rst      (rst),
        .load_i   (1'b1),
        .bubble_i (flush | stall),
        .hi_we_i  (m_hi_we),
        .lo_we_i  (m_lo_we),
        .hi_i     (m_hi),
        .lo_i     (m_lo),
        .hi_we_o  (w_hi_we),
        .lo_we_o  (w_lo_we),
        .hi_o     (w_hi),
        .lo_o     (w_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wr_valid(w_hi_we, w_lo_we)) begin
            if (|w_hi_we) hi_q <= w_hi;
            if (|w_lo_we) lo_q <= w_lo;
        end
    end

`ifdef HILO_FWD_EN
    logic unused_rd;
    assign unused_rd = e_rd_hi ^ e_rd_lo;

    // Youngest in-flight write wins: M before W before architectural.
    always_comb begin
        hi_out = hi_q;
        lo_out = lo_q;
        if (|m_hi_we)      hi_out = m_hi;
        else if (|w_hi_we) hi_out = w_hi;
        if (|m_lo_we)      lo_out = m_lo;
        else if (|w_lo_we) lo_out = w_lo;
    end
    assign stall_req = 1'b0;
`else
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign stall_req = (e_rd_hi & ((|m_hi_we) | (|w_hi_we)))
                     | (e_rd_lo & ((|m_lo_we) | (|w_lo_we)));
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized + directed bench for hilo_unit against an in-flight-write reference model.
module tb_hilo_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, stall, flush;
    logic          e_hi_we, e_lo_we, e_rd_hi, e_rd_lo;
    logic [DW-1:0] e_hi, e_lo, hi_out, lo_out;
    logic          stall_req;

    always #5 clk = ~clk;

    hilo_unit #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .e_hi_we   (e_hi_we),
        .e_lo_we   (e_lo_we),
        .e_hi      (e_hi),
        .e_lo      (e_lo),
        .e_rd_hi   (e_rd_hi),
        .e_rd_lo   (e_rd_lo),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .stall_req (stall_req)
    );

    // Model: in-flight writes kept as records "one edge from commit" (w) and "two edges" (m).
    typedef struct {
        bit            hwe;
        bit            lwe;
        logic [DW-1:0] h;
        logic [DW-1:0] l;
    } rec_t;

    rec_t          mm, ww, nop;
    logic [DW-1:0] arch_hi, arch_lo;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            mm = nop; ww = nop; arch_hi = '0; arch_lo = '0;
        end else begin
            if (ww.hwe) arch_hi = ww.h;
            if (ww.lwe) arch_lo = ww.l;
            if (flush) begin
                mm = nop; ww = nop;
            end else if (stall) begin
                ww = nop;
            end else begin
                ww = mm;
                mm = '{hwe: e_hi_we, lwe: e_lo_we, h: e_hi, l: e_lo};
            end
        end
    endtask

    // Drive one cycle at negedge, check combinational outputs, take the edge.
    task automatic cyc(input bit r, input bit s, input bit f, input bit hw, input bit lw,
                       input logic [DW-1:0] h, input logic [DW-1:0] l, input bit rh, input bit rl);
        logic [DW-1:0] xh, xl;
        logic          xs;
        rst = r; stall = s; flush = f; e_hi_we = hw; e_lo_we = lw;
        e_hi = h; e_lo = l; e_rd_hi = rh; e_rd_lo = rl;
        #1;
`ifdef HILO_FWD_EN
        xh = mm.hwe ? mm.h : (ww.hwe ? ww.h : arch_hi);
        xl = mm.lwe ? mm.l : (ww.lwe ? ww.l : arch_lo);
        xs = 1'b0;
`else
        xh = arch_hi;
        xl = arch_lo;
        xs = (rh && (mm.hwe || ww.hwe)) || (rl && (mm.lwe || ww.lwe));
`endif
        chk("hi_out", hi_out, xh);
        chk("lo_out", lo_out, xl);
        chk("stall_req", DW'(stall_req), DW'(xs));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    initial begin
        int n;
        nop = '{hwe: 1'b0, lwe: 1'b0, h: '0, l: '0};
        mm = nop; ww = nop; arch_hi = '0; arch_lo = '0;
        rst = 1; stall = 0; flush = 0; e_hi_we = 0; e_lo_we = 0;
        e_hi = '0; e_lo = '0; e_rd_hi = 0; e_rd_lo = 0;
        @(posedge clk);
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, '0, '0, 1, 1);

        // Idle after reset, with reads requested
        cyc(0, 0, 0, 0, 0, '0, '0, 1, 1);
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        e_rd_hi = 1; e_rd_lo = 1; #1;
        chk("rst_sreq", DW'(stall_req), '0);

        // MULT: architectural after 3 edges
        cyc(0, 0, 0, 1, 1, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0);
`ifdef HILO_FWD_EN
        chk("mult_fwd_hi", hi_out, 32'h1);
        chk("mult_fwd_lo", lo_out, 32'hFFFF_FFFE);
`else
        chk("mult_e1_hi", hi_out, 32'h0);
`endif
        idle();
`ifndef HILO_FWD_EN
        chk("mult_e2_hi", hi_out, 32'h0);
        chk("mult_e2_lo", lo_out, 32'h0);
`endif
        idle();
        chk("mult_arch_hi", hi_out, 32'h1);
        chk("mult_arch_lo", lo_out, 32'hFFFF_FFFE);

        // Back-to-back MTHI: M beats W, LO untouched
        cyc(1, 0, 0, 0, 0, '0, '0, 0, 0);
        cyc(0, 0, 0, 1, 0, 32'hAAAA_AAAA, 32'h9999, 0, 0);
        cyc(0, 0, 0, 1, 0, 32'h5555_5555, 32'h8888, 0, 0);
`ifdef HILO_FWD_EN
        chk("mthi_mw_hi", hi_out, 32'h5555_5555);
`endif
        chk("mthi_lo", lo_out, 32'h0);
        idle(); idle();
        chk("mthi_arch_hi", hi_out, 32'h5555_5555);
        chk("mthi_arch_lo", lo_out, 32'h0);

        // MTLO flushed while in M never reaches LO
        cyc(0, 0, 0, 0, 1, '0, 32'h1234, 0, 0);
        cyc(0, 0, 1, 0, 0, '0, '0, 0, 0);
        idle(); idle();
        chk("flush_lo", lo_out, 32'h0);

        // Read hazard: the MFHI is held at E while stall_req is high; the
        // held instruction issues no write, so the unit sees write-less E slots.
        cyc(0, 0, 0, 1, 0, 32'h77, '0, 0, 0);
        n = 0;
        while (n < 10) begin
            e_rd_hi = 1; e_hi_we = 0; e_lo_we = 0; #1;
            if (!stall_req) break;
            n++;
            cyc(0, 0, 0, 0, 0, '0, '0, 1, 0);
        end
`ifdef HILO_FWD_EN
        chk("haz_cycles", DW'(n), 32'd0);
`else
        chk("haz_cycles", DW'(n), 32'd2);
`endif
        chk("haz_hi", hi_out, 32'h77);
        chk("haz_sreq", DW'(stall_req), '0);
        cyc(0, 0, 0, 0, 0, '0, '0, 1, 0);

        // Reset beats a pending commit in W
        cyc(0, 0, 0, 1, 0, 32'hDEAD, '0, 0, 0);
        idle();
        cyc(1, 1, 1, 0, 0, '0, '0, 0, 0);
        chk("rstw_hi", hi_out, 32'h0);
        idle();
        chk("rstw_hi2", hi_out, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] rh, rl;
            rh = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
            rl = DW'($urandom);
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), rh, rl,
                ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
